// File: rtl/hdmi_axi_pkg.sv
// Shared types and width helpers for the HDMI frame read address path.
// Everything here runs in the clk_vga domain.
package hdmi_axi_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LINE = 2'd2
  } state_t;

  localparam int AHEAD_W = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int pix_shift(input int bpp);
    return $clog2(bpp);
  endfunction

endpackage

// File: rtl/hdmi_line_credit.sv
// Scan-out line tracking: counts display-enable falling edges and decides
// whether the prefetcher may open another line.
module hdmi_line_credit
  import hdmi_axi_pkg::*;
#(
  parameter int Y_SIZE      = 256,
  parameter int LINES_AHEAD = 2,
  parameter int Y_W         = cnt_w(256)
) (
  input  logic           clk_vga,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           cnt_en,
  input  logic           de,
  input  logic [Y_W-1:0] line_idx,
  output logic           line_ok
);

  localparam int SW = Y_W + AHEAD_W + 1;

  logic           de_d;
  logic           fall;
  logic [Y_W-1:0] consumed;

  assign fall = de_d & ~de;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      de_d     <= 1'b0;
      consumed <= '0;
    end else begin
      de_d <= de;
      if (clr) begin
        consumed <= '0;
      end else if (cnt_en && fall &&
                   consumed != Y_W'(Y_SIZE)) begin
        consumed <= consumed + 1'b1;
      end
    end
  end

  // Scan-out running ahead of prefetch counts as credit, never as a stall.
  assign line_ok = SW'(line_idx) <
                   SW'(consumed) + SW'(LINES_AHEAD);

endmodule

// File: rtl/hdmi_frame_read_addr.sv
// Per-frame DRAM read burst command generator feeding the AXI read master,
// with double buffering, lines-ahead flow control and frame abort.
module hdmi_frame_read_addr
  import hdmi_axi_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int X_SIZE        = 256,
  parameter int Y_SIZE        = 256,
  parameter int BURST_PIX     = 64,
  parameter int BYTES_PER_PIX = 4,
  parameter int LINE_STRIDE   = 1024,
  parameter int LINES_AHEAD   = 2,
  parameter int LEN_W         = 8
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              de,
  input  logic [ADDR_W-1:0] base_addr0,
  input  logic [ADDR_W-1:0] base_addr1,
  input  logic              buf_sel,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int X_W       = cnt_w(X_SIZE);
  localparam int Y_W       = cnt_w(Y_SIZE);
  localparam int PIX_SHIFT = pix_shift(BYTES_PER_PIX);

  state_t            state;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] lb_nx;
  logic [ADDR_W-1:0] pend_base;
  logic [ADDR_W-1:0] sel_base;
  logic [ADDR_W-1:0] st_base;
  logic [X_W-1:0]    x;
  logic [X_W-1:0]    x_nx;
  logic [Y_W-1:0]    y;
  logic [Y_W-1:0]    y_nx;
  logic [Y_W-1:0]    line_idx;
  logic              pend;
  logic              pend_en;
  logic              st_req;
  logic              st_en;
  logic              acc;
  logic              eol;
  logic              last;
  logic              restart;
  logic              stop;
  logic              aborting;
  logic              line_ok;

  function automatic logic [LEN_W-1:0] burst_len(
    input logic [X_W-1:0] xp
  );
    logic [X_W-1:0] rem;
    rem = X_W'(X_SIZE) - xp;
    return (int'(rem) > BURST_PIX) ?
           LEN_W'(BURST_PIX) : LEN_W'(rem);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [ADDR_W-1:0] lb,
    input logic [X_W-1:0]    xp
  );
    return lb + (ADDR_W'(xp) << PIX_SHIFT);
  endfunction

  assign sel_base   = buf_sel ? base_addr1 : base_addr0;
  // A start deferred behind a stalled command overrides nothing newer.
  assign st_req     = frame_start | pend;
  assign st_en      = frame_start ? enable : pend_en;
  assign st_base    = frame_start ? sel_base : pend_base;
  assign acc        = (state == ISSUE) && cmd_ready;
  assign frame_busy = (state != IDLE);

  always_comb begin
    x_nx  = x + X_W'(cmd_len);
    y_nx  = y;
    lb_nx = line_base;
    eol   = (x_nx == X_W'(X_SIZE));
    if (eol) begin
      x_nx  = '0;
      y_nx  = y + 1'b1;
      lb_nx = line_base + ADDR_W'(LINE_STRIDE);
    end
    last = eol && (y_nx == Y_W'(Y_SIZE));
  end

  assign line_idx = (state == ISSUE) ? y_nx : y;

  assign restart =
    (state == IDLE && frame_start && enable) ||
    (acc && st_req && st_en) ||
    (state == WAIT_LINE && frame_start && enable);

  assign stop =
    (acc && (st_req ? !st_en : last)) ||
    (state == WAIT_LINE && frame_start && !enable);

  assign aborting =
    (acc && st_req && !last) ||
    (state == WAIT_LINE && frame_start);

  hdmi_line_credit #(
    .Y_SIZE      (Y_SIZE),
    .LINES_AHEAD (LINES_AHEAD),
    .Y_W         (Y_W)
  ) u_credit (
    .clk_vga  (clk_vga),
    .rst_n    (rst_n),
    .clr      (restart),
    .cnt_en   (frame_busy),
    .de       (de),
    .line_idx (line_idx),
    .line_ok  (line_ok)
  );

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_base   <= '0;
      pend_base   <= '0;
      x           <= '0;
      y           <= '0;
      pend        <= 1'b0;
      pend_en     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= acc && last;
      frame_abort <= aborting;
      if (restart) begin
        state     <= ISSUE;
        line_base <= st_base;
        x         <= '0;
        y         <= '0;
        pend      <= 1'b0;
        cmd_valid <= 1'b1;
        cmd_addr  <= st_base;
        cmd_len   <= burst_len('0);
      end else if (stop) begin
        state     <= IDLE;
        cmd_valid <= 1'b0;
        pend      <= 1'b0;
      end else if (acc) begin
        x         <= x_nx;
        y         <= y_nx;
        line_base <= lb_nx;
        cmd_addr  <= pix_addr(lb_nx, x_nx);
        cmd_len   <= burst_len(x_nx);
        if (eol && !line_ok) begin
          state     <= WAIT_LINE;
          cmd_valid <= 1'b0;
        end
      end else if (state == ISSUE && frame_start) begin
        pend      <= 1'b1;
        pend_en   <= enable;
        pend_base <= sel_base;
      end else if (state == WAIT_LINE && line_ok) begin
        state     <= ISSUE;
        cmd_valid <= 1'b1;
      end
    end
  end

endmodule
